// File: rtl/alu_flag_wb.sv
// Writeback stage after the 8-bit add/sub ALU: derives C/Z/N/V per result and
// buffers {result,c,z,n,v} entries in a small FIFO toward the register file/PSW.
module alu_flag_wb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

  entry_t          mem [DEPTH];
  entry_t          push_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [CW-1:0]   count, count_nx;
  occ_t            occ;
  logic            push, pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid here come only from registered occupancy.
  always_comb begin
    occ = PARTIAL;
    if (count == '0)                occ = EMPTY;
    else if (count == CW'(DEPTH))   occ = FULL;
  end

  assign in_ready  = (occ != FULL);
  assign out_valid = (occ != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Subtract carry is inverted into a borrow; overflow uses the operand signs
  // as the ALU saw them, with b un-inverted.
  always_comb begin
    push_entry.result = in_sum;
    push_entry.z      = (in_sum == '0);
    push_entry.n      = in_sum[WIDTH-1];
    if (in_sub) begin
      push_entry.c = ~in_cout;
      push_entry.v = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (in_sum[WIDTH-1] != in_a[WIDTH-1]);
    end else begin
      push_entry.c = in_cout;
      push_entry.v = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (in_sum[WIDTH-1] != in_a[WIDTH-1]);
    end
  end

  always_comb begin
    count_nx  = count;
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    if (flush) begin
      count_nx  = '0;
      wr_ptr_nx = '0;
      rd_ptr_nx = '0;
    end else begin
      if (push) wr_ptr_nx = wr_ptr + AW'(1);
      if (pop)  rd_ptr_nx = rd_ptr + AW'(1);
      if (push && !pop)      count_nx = count + CW'(1);
      else if (pop && !push) count_nx = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count  <= count_nx;
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= push_entry;
  end

  assign head       = mem[rd_ptr];
  assign out_result = out_valid ? head.result : '0;
  assign out_c      = out_valid & head.c;
  assign out_z      = out_valid & head.z;
  assign out_n      = out_valid & head.n;
  assign out_v      = out_valid & head.v;

endmodule
